// File: rtl/word_bank_pkg.sv
// Shared types and constants for the word bank sequencer.
package word_bank_pkg;

  localparam int unsigned NWORDS = 16;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/word_bank_sequencer_sel_dwell_ctr.sv
// Dwell counter: loads a hold count, counts down while enabled, flags zero.
module sel_dwell_ctr #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/word_bank_sequencer.sv
// 16-word bank feeding a downstream 16:1 selector, plus a timed select scan.
// Optional macro BANK_LOCK_EN: once loaded, clr is ignored (write-once bank until rst).
module word_bank_sequencer
  import word_bank_pkg::*;
#(
  parameter int unsigned DWELL = 1,
  parameter int unsigned DW    = DEF_DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [DW-1:0]    wr_data,
  input  logic             start,
  output logic [DW-1:0]    word0,
  output logic [DW-1:0]    word1,
  output logic [DW-1:0]    word2,
  output logic [DW-1:0]    word3,
  output logic [DW-1:0]    word4,
  output logic [DW-1:0]    word5,
  output logic [DW-1:0]    word6,
  output logic [DW-1:0]    word7,
  output logic [DW-1:0]    word8,
  output logic [DW-1:0]    word9,
  output logic [DW-1:0]    word10,
  output logic [DW-1:0]    word11,
  output logic [DW-1:0]    word12,
  output logic [DW-1:0]    word13,
  output logic [DW-1:0]    word14,
  output logic [DW-1:0]    word15,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             loaded,
  output logic             busy,
  output logic             done
);

  localparam logic [7:0]       DWELL_M1 = 8'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NWORDS - 1);

  state_t           state, state_n;
  logic [SEL_W-1:0] sel_n;
  logic [SEL_W-1:0] ptr;
  logic [DW-1:0]    bank [NWORDS];
  logic             go, clr_fire, wr_fire, dwell_load, dwell_tc, clr_ok;

`ifdef BANK_LOCK_EN
  assign clr_ok = !loaded;
`else
  assign clr_ok = 1'b1;
`endif

  sel_dwell_ctr #(.W(8)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (dwell_load),
    .en       (state == SCAN),
    .load_val (DWELL_M1),
    .tc       (dwell_tc)
  );

  always_comb begin
    state_n    = state;
    sel_n      = sel;
    go         = 1'b0;
    clr_fire   = 1'b0;
    wr_fire    = 1'b0;
    dwell_load = 1'b0;
    case (state)
      IDLE: begin
        go       = start && loaded;
        // A clear that takes effect cancels a coincident write.
        clr_fire = clr && clr_ok && !go;
        wr_fire  = wr_valid && !loaded && !clr_fire;
        if (go) begin
          state_n    = SCAN;
          sel_n      = '0;
          dwell_load = 1'b1;
        end
      end
      SCAN: begin
        if (dwell_tc) begin
          if (sel == LAST_IDX) begin
            state_n = DONE;
            sel_n   = '0;
          end else begin
            sel_n      = sel + 1'b1;
            dwell_load = 1'b1;
          end
        end
      end
      DONE: state_n = IDLE;
      default: begin
        state_n = IDLE;
        sel_n   = '0;
      end
    endcase
  end

  assign wr_ready  = (state == IDLE) && !loaded;
  assign sel_valid = (state == SCAN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= '0;
      ptr    <= '0;
      loaded <= 1'b0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      if (clr_fire) begin
        ptr    <= '0;
        loaded <= 1'b0;
      end else if (wr_fire) begin
        ptr <= ptr + 1'b1;
        if (ptr == LAST_IDX) loaded <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NWORDS; i++) bank[i] <= '0;
    end else if (wr_fire) begin
      bank[ptr] <= wr_data;
    end
  end

  assign word0  = bank[0];
  assign word1  = bank[1];
  assign word2  = bank[2];
  assign word3  = bank[3];
  assign word4  = bank[4];
  assign word5  = bank[5];
  assign word6  = bank[6];
  assign word7  = bank[7];
  assign word8  = bank[8];
  assign word9  = bank[9];
  assign word10 = bank[10];
  assign word11 = bank[11];
  assign word12 = bank[12];
  assign word13 = bank[13];
  assign word14 = bank[14];
  assign word15 = bank[15];

endmodule

// File: tb/tb_word_bank_sequencer.sv
// Bench for word_bank_sequencer: DWELL=1 and DWELL=3 instances against a scan-time reference model.
module tb_word_bank_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;

  logic        o_rdy [2];
  logic [3:0]  o_sel [2];
  logic        o_sv  [2];
  logic        o_ld  [2];
  logic        o_busy[2];
  logic        o_done[2];
  logic [31:0] o_w   [2][16];

  int checks = 0;
  int errors = 0;
  bit run_checks = 1'b0;

  // Reference model: scan progress is a plain elapsed-cycle count t (-1 = idle).
  int          dw [2] = '{1, 3};
  logic [31:0] m_bank [2][16];
  int          m_ptr [2];
  logic        m_loaded [2];
  int          m_t [2];

  always #5 clk = ~clk;

  word_bank_sequencer #(.DWELL(1), .DW(32)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .wr_valid(wr_valid), .wr_ready(o_rdy[0]),
    .wr_data(wr_data), .start(start),
    .word0(o_w[0][0]), .word1(o_w[0][1]), .word2(o_w[0][2]), .word3(o_w[0][3]),
    .word4(o_w[0][4]), .word5(o_w[0][5]), .word6(o_w[0][6]), .word7(o_w[0][7]),
    .word8(o_w[0][8]), .word9(o_w[0][9]), .word10(o_w[0][10]), .word11(o_w[0][11]),
    .word12(o_w[0][12]), .word13(o_w[0][13]), .word14(o_w[0][14]), .word15(o_w[0][15]),
    .sel(o_sel[0]), .sel_valid(o_sv[0]), .loaded(o_ld[0]), .busy(o_busy[0]), .done(o_done[0])
  );

  word_bank_sequencer #(.DWELL(3), .DW(32)) dut3 (
    .clk(clk), .rst(rst), .clr(clr), .wr_valid(wr_valid), .wr_ready(o_rdy[1]),
    .wr_data(wr_data), .start(start),
    .word0(o_w[1][0]), .word1(o_w[1][1]), .word2(o_w[1][2]), .word3(o_w[1][3]),
    .word4(o_w[1][4]), .word5(o_w[1][5]), .word6(o_w[1][6]), .word7(o_w[1][7]),
    .word8(o_w[1][8]), .word9(o_w[1][9]), .word10(o_w[1][10]), .word11(o_w[1][11]),
    .word12(o_w[1][12]), .word13(o_w[1][13]), .word14(o_w[1][14]), .word15(o_w[1][15]),
    .sel(o_sel[1]), .sel_valid(o_sv[1]), .loaded(o_ld[1]), .busy(o_busy[1]), .done(o_done[1])
  );

`ifdef BANK_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_t[k]      <= -1;
        m_ptr[k]    <= 0;
        m_loaded[k] <= 1'b0;
        for (int i = 0; i < 16; i++) m_bank[k][i] <= '0;
      end else if (m_t[k] == 16 * dw[k]) begin
        m_t[k] <= -1;
      end else if (m_t[k] >= 0) begin
        m_t[k] <= m_t[k] + 1;
      end else if (start && m_loaded[k]) begin
        m_t[k] <= 0;
      end else if (clr && !(LOCK && m_loaded[k])) begin
        m_ptr[k]    <= 0;
        m_loaded[k] <= 1'b0;
      end else if (wr_valid && !m_loaded[k]) begin
        m_bank[k][m_ptr[k]] <= wr_data;
        m_ptr[k]            <= (m_ptr[k] + 1) % 16;
        if (m_ptr[k] == 15) m_loaded[k] <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      bit scanning;
      scanning = (m_t[k] >= 0) && (m_t[k] < 16 * dw[k]);
      check($sformatf("sel_valid[%0d]", k), 64'(o_sv[k]), 64'(scanning));
      check($sformatf("sel[%0d]", k), 64'(o_sel[k]), scanning ? 64'(m_t[k] / dw[k]) : 64'd0);
      check($sformatf("done[%0d]", k), 64'(o_done[k]), 64'(m_t[k] == 16 * dw[k]));
      check($sformatf("busy[%0d]", k), 64'(o_busy[k]), 64'(m_t[k] >= 0));
      check($sformatf("loaded[%0d]", k), 64'(o_ld[k]), 64'(m_loaded[k]));
      check($sformatf("wr_ready[%0d]", k), 64'(o_rdy[k]), 64'((m_t[k] < 0) && !m_loaded[k]));
      for (int i = 0; i < 16; i++)
        check($sformatf("word%0d[%0d]", i, k), 64'(o_w[k][i]), 64'(m_bank[k][i]));
    end
  endtask

  always @(negedge clk) if (run_checks) compare_all();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 compare_all();
    check("done_in_rst", 64'(o_done[0] | o_done[1]), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic write_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 32'(i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic run_scan(input bit measure);
    int lat0, lat1;
    lat0 = 0;
    lat1 = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 2; n <= 120; n++) begin
      tick();
      if (o_done[0] && lat0 == 0) lat0 = n;
      if (o_done[1] && lat1 == 0) lat1 = n;
      if (lat1 != 0) break;
    end
    if (measure) begin
      check("latency_dwell1", 64'(lat0), 64'd17);
      check("latency_dwell3", 64'(lat1), 64'd49);
    end else begin
      check("rescan_done", 64'(lat1 != 0), 64'd1);
    end
    tick();
  endtask

  initial begin
    int found;
    repeat (2) @(negedge clk);
    run_checks = 1'b1;
    @(negedge clk);
    check("reset_wr_ready", 64'(o_rdy[0]), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Full load with wr_valid held high
    write_words(16, 32'hA000_0000);
    check("loaded_after_16", 64'(o_ld[0]), 64'd1);
    check("wr_ready_after_16", 64'(o_rdy[1]), 64'd0);
    check("word12", 64'(o_w[0][12]), 64'hA000_000C);
    wr_valid = 1'b1;
    wr_data  = 32'hFFFF_FFFF;
    tick();
    wr_valid = 1'b0;
    check("no_overwrite", 64'(o_w[1][0]), 64'hA000_0000);

    run_scan(1'b1);

    // Start with only 8 words loaded is ignored
    pulse_reset();
    write_words(8, 32'hC000_0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("partial_busy", 64'(o_busy[0] | o_busy[1]), 64'd0);
    check("partial_sel_valid", 64'(o_sv[0] | o_sv[1]), 64'd0);

    // Clear coinciding with the 5th write handshake
    pulse_reset();
    write_words(4, 32'hB000_0000);
    wr_valid = 1'b1;
    wr_data  = 32'hDEAD_BEEF;
    clr      = 1'b1;
    tick();
    clr      = 1'b0;
    wr_valid = 1'b0;
    check("clr_drops_word4", 64'(o_w[0][4]), 64'd0);
    write_words(1, 32'h5555_0000);
    check("ptr_back_to_0", 64'(o_w[0][0]), 64'h5555_0000);

    // Clear after a full load
    pulse_reset();
    write_words(16, 32'hD000_0000);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_after_load", 64'(o_ld[0]), LOCK ? 64'd1 : 64'd0);

    // Reset in the middle of a scan, then reload and rescan
    pulse_reset();
    write_words(16, 32'hE000_0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int n = 0; n < 40; n++) begin
      if (o_sv[0] && o_sel[0] == 4'd7) begin
        found = 1;
        break;
      end
      tick();
    end
    check("reach_sel7", 64'(found), 64'd1);
    #2 rst = 1'b1;
    #1 compare_all();
    check("abort_sel", 64'(o_sel[0]), 64'd0);
    check("abort_done", 64'(o_done[0] | o_done[1]), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rdy_after_rst", 64'(o_rdy[0]), 64'd1);
    write_words(16, 32'hF000_0000);
    run_scan(1'b0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = $urandom;
      clr      = ($urandom_range(0, 19) == 0);
      start    = ($urandom_range(0, 5) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst      = 1'b0;
    wr_valid = 1'b0;
    clr      = 1'b0;
    start    = 1'b0;
    repeat (3) tick();

    run_checks = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1);
  end

endmodule
